// File: rtl/gshare_predictor.sv
// gshare branch direction predictor.
// A table of saturating counters is indexed by PC[INDEX_WIDTH:1] XOR a
// speculative global history register (GHR). The decoder reads it
// combinationally. The reorder buffer trains a counter when a branch
// resolves, and on a misprediction it also rebuilds the GHR.
// Two free-running saturating counters record queries and mispredictions.
module gshare_predictor #(
   parameter int INDEX_WIDTH = 6,
   parameter int CNT_WIDTH   = 2,
   parameter int HIST_WIDTH  = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  rdy_in,
   input  logic                  query_en,
   input  logic [31:0]           query_pc,
   output logic                  query_taken,
   output logic [HIST_WIDTH-1:0] query_history,
   input  logic                  update_en,
   input  logic [31:0]           update_pc,
   input  logic [HIST_WIDTH-1:0] update_history,
   input  logic                  update_taken,
   input  logic                  update_mispredict,
   output logic [31:0]           stat_predictions,
   output logic [31:0]           stat_mispredicts
);

   localparam int ENTRIES = 1 << INDEX_WIDTH;

   // Weakly not-taken: MSB clear, all lower bits set.
   localparam logic [CNT_WIDTH-1:0] CNT_INIT = {1'b0, {(CNT_WIDTH-1){1'b1}}};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_MIN  = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   // Table index. PC bit 0 is dropped because compressed instructions sit
   // on 2-byte boundaries. The history is zero-extended to the index width.
   function automatic logic [INDEX_WIDTH-1:0] index_f(
      input logic [31:0]           pc,
      input logic [HIST_WIDTH-1:0] hist
   );
      logic [INDEX_WIDTH-1:0] hist_ext;
      hist_ext                   = {INDEX_WIDTH{1'b0}};
      hist_ext[HIST_WIDTH-1:0]   = hist;
      return pc[INDEX_WIDTH:1] ^ hist_ext;
   endfunction

   // Shift a new outcome into the history.
   // This formulation also holds when HIST_WIDTH is 1.
   function automatic logic [HIST_WIDTH-1:0] shift_f(
      input logic [HIST_WIDTH-1:0] hist,
      input logic                  outcome
   );
      logic [HIST_WIDTH:0] wide;
      wide = {hist, outcome};
      return wide[HIST_WIDTH-1:0];
   endfunction

   // Move a counter one step toward the resolved direction.
   // The counter saturates at both ends.
   function automatic logic [CNT_WIDTH-1:0] train_f(
      input logic [CNT_WIDTH-1:0] cnt,
      input logic                 taken
   );
      logic [CNT_WIDTH-1:0] res;
      if (taken) begin
         res = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
      end else begin
         res = (cnt == CNT_MIN) ? cnt : cnt - CNT_ONE;
      end
      return res;
   endfunction

   // Event counter that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc_f(input logic [31:0] val);
      return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
   endfunction

   // State
   logic [CNT_WIDTH-1:0]   cnt_q [ENTRIES];
   logic [HIST_WIDTH-1:0]  ghr_q;
   logic [HIST_WIDTH-1:0]  ghr_d;
   logic [31:0]            pred_cnt_q;
   logic [31:0]            pred_cnt_d;
   logic [31:0]            misp_cnt_q;
   logic [31:0]            misp_cnt_d;
   logic [CNT_WIDTH-1:0]   cnt_d;

   // Decode
   logic [INDEX_WIDTH-1:0] query_idx_s;
   logic [INDEX_WIDTH-1:0] upd_idx_s;
   logic [CNT_WIDTH-1:0]   query_cnt_s;
   logic [CNT_WIDTH-1:0]   upd_cnt_s;
   logic                   upd_acc_s;
   logic                   repair_s;
   logic                   query_acc_s;

   // Only PC[INDEX_WIDTH:1] takes part in indexing. The remaining bits are
   // folded into one unused net so the intent is explicit.
   logic unused_pc_bits_s;
   assign unused_pc_bits_s = ^{query_pc[31:INDEX_WIDTH+1], query_pc[0],
                               update_pc[31:INDEX_WIDTH+1], update_pc[0]};

   // Combinational query path, read-before-write, plus acceptance qualifiers.
   always_comb begin
      query_idx_s   = index_f(query_pc, ghr_q);
      upd_idx_s     = index_f(update_pc, update_history);
      query_cnt_s   = cnt_q[query_idx_s];
      upd_cnt_s     = cnt_q[upd_idx_s];
      query_taken   = query_cnt_s[CNT_WIDTH-1];
      query_history = ghr_q;
      upd_acc_s     = rdy_in & update_en;
      repair_s      = rdy_in & update_en & update_mispredict;
      // A repair flushes the decoder, so a same-cycle query is dropped.
      query_acc_s   = rdy_in & query_en & ~(update_en & update_mispredict);
   end

   // Next-state logic for the trained counter, the GHR and the statistics.
   always_comb begin
      cnt_d      = train_f(upd_cnt_s, update_taken);
      ghr_d      = ghr_q;
      pred_cnt_d = pred_cnt_q;
      misp_cnt_d = misp_cnt_q;
      if (repair_s) begin
         ghr_d      = shift_f(update_history, update_taken);
         misp_cnt_d = sat_inc_f(misp_cnt_q);
      end else if (query_acc_s) begin
         ghr_d      = shift_f(ghr_q, query_taken);
         pred_cnt_d = sat_inc_f(pred_cnt_q);
      end else begin
         ghr_d      = ghr_q;
      end
   end

   // Counter table: reset every entry to weakly not-taken; train one entry per update.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < ENTRIES; i++) begin
            cnt_q[i] <= CNT_INIT;
         end
      end else if (upd_acc_s) begin
         cnt_q[upd_idx_s] <= cnt_d;
      end
   end

   // GHR and statistics registers.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         ghr_q      <= {HIST_WIDTH{1'b0}};
         pred_cnt_q <= 32'd0;
         misp_cnt_q <= 32'd0;
      end else begin
         ghr_q      <= ghr_d;
         pred_cnt_q <= pred_cnt_d;
         misp_cnt_q <= misp_cnt_d;
      end
   end

   assign stat_predictions = pred_cnt_q;
   assign stat_mispredicts = misp_cnt_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Testbench for gshare_predictor.
// It applies a directed vector table, then a hand-written asynchronous
// reset sequence, then randomized traffic checked against a behavioural model.
module tb_gshare_predictor;

   localparam int IW = 6;
   localparam int CW = 2;
   localparam int HW = 4;

   logic          clk, rst_n, rdy, qen, qt, uen, ut, um;
   logic [31:0]   qpc, upc, sp, sm;
   logic [HW-1:0] qh, uh;

   int n_cmp = 0;
   int n_err = 0;

   gshare_predictor #(.INDEX_WIDTH(IW), .CNT_WIDTH(CW), .HIST_WIDTH(HW)) dut (
      .clk_in            (clk),
      .rst_n_in          (rst_n),
      .rdy_in            (rdy),
      .query_en          (qen),
      .query_pc          (qpc),
      .query_taken       (qt),
      .query_history     (qh),
      .update_en         (uen),
      .update_pc         (upc),
      .update_history    (uh),
      .update_taken      (ut),
      .update_mispredict (um),
      .stat_predictions  (sp),
      .stat_mispredicts  (sm)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic          rdy;
      logic          qen;
      logic [31:0]   qpc;
      logic          uen;
      logic [31:0]   upc;
      logic [HW-1:0] uh;
      logic          ut;
      logic          um;
      logic          e_taken;
      logic [HW-1:0] e_hist;
      logic [31:0]   e_pred;
      logic [31:0]   e_misp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic q, input logic [31:0] qp,
                               input logic u, input logic [31:0] up, input logic [HW-1:0] h,
                               input logic t, input logic m, input logic et,
                               input logic [HW-1:0] eh, input logic [31:0] ep, input logic [31:0] em);
      vec_t v;
      v.rdy = r; v.qen = q; v.qpc = qp; v.uen = u; v.upc = up; v.uh = h;
      v.ut = t; v.um = m; v.e_taken = et; v.e_hist = eh; v.e_pred = ep; v.e_misp = em;
      return v;
   endfunction

   // Behavioural reference model.
   int     mcnt[1 << IW];
   int     mghr;
   longint mpred, mmisp;

   function automatic void model_reset();
      for (int i = 0; i < (1 << IW); i++) mcnt[i] = (1 << (CW - 1)) - 1;
      mghr  = 0;
      mpred = 0;
      mmisp = 0;
   endfunction

   function automatic int midx(input logic [31:0] pc, input int h);
      return int'((pc / 32'd2) % 32'(1 << IW)) ^ h;
   endfunction

   function automatic logic model_taken();
      return mcnt[midx(qpc, mghr)] >= (1 << (CW - 1));
   endfunction

   function automatic void model_step();
      logic t;
      int   i;
      if (rdy) begin
         t = model_taken();
         if (uen) begin
            i = midx(upc, int'(uh));
            if (ut) mcnt[i] = (mcnt[i] + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : mcnt[i] + 1;
            else    mcnt[i] = (mcnt[i] - 1 < 0) ? 0 : mcnt[i] - 1;
         end
         if (uen && um) begin
            mghr  = (int'(uh) * 2 + int'(ut)) % (1 << HW);
            mmisp = (mmisp + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mmisp + 1;
         end else if (qen) begin
            mghr  = (mghr * 2 + int'(t)) % (1 << HW);
            mpred = (mpred + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mpred + 1;
         end
      end
   endfunction

   initial begin
      rst_n = 1'b0; rdy = 1'b1; qen = 1'b0; qpc = 32'd0; uen = 1'b0;
      upc = 32'd0; uh = 4'd0; ut = 1'b0; um = 1'b0;

      // Reset state
      vecs.push_back(mk(1'b1,1'b0,32'h0,  1'b0,32'h0,4'd0,1'b0,1'b0, 1'b0,4'd0,32'd0,32'd0));
      vecs.push_back(mk(1'b1,1'b0,32'h100,1'b0,32'h0,4'd0,1'b0,1'b0, 1'b0,4'd0,32'd0,32'd0));
      vecs.push_back(mk(1'b1,1'b0,32'h7E, 1'b0,32'h0,4'd0,1'b0,1'b0, 1'b0,4'd0,32'd0,32'd0));
      // Train counter[0] up to 3, then saturate it down at 0
      vecs.push_back(mk(1'b1,1'b0,32'h100,1'b1,32'h100,4'd0,1'b1,1'b0, 1'b0,4'd0,32'd0,32'd0));
      vecs.push_back(mk(1'b1,1'b0,32'h100,1'b1,32'h100,4'd0,1'b1,1'b0, 1'b1,4'd0,32'd0,32'd0));
      vecs.push_back(mk(1'b1,1'b0,32'h100,1'b0,32'h0,  4'd0,1'b0,1'b0, 1'b1,4'd0,32'd0,32'd0));
      vecs.push_back(mk(1'b1,1'b0,32'h100,1'b1,32'h100,4'd0,1'b0,1'b0, 1'b1,4'd0,32'd0,32'd0));
      vecs.push_back(mk(1'b1,1'b0,32'h100,1'b1,32'h100,4'd0,1'b0,1'b0, 1'b1,4'd0,32'd0,32'd0));
      vecs.push_back(mk(1'b1,1'b0,32'h100,1'b1,32'h100,4'd0,1'b0,1'b0, 1'b0,4'd0,32'd0,32'd0));
      vecs.push_back(mk(1'b1,1'b0,32'h100,1'b1,32'h100,4'd0,1'b0,1'b0, 1'b0,4'd0,32'd0,32'd0));
      vecs.push_back(mk(1'b1,1'b0,32'h100,1'b1,32'h100,4'd0,1'b0,1'b0, 1'b0,4'd0,32'd0,32'd0));
      vecs.push_back(mk(1'b1,1'b0,32'h100,1'b0,32'h0,  4'd0,1'b0,1'b0, 1'b0,4'd0,32'd0,32'd0));
      // Train counters 32, 33 and 35 (pc 0x40 with h = 0, 1, 3)
      vecs.push_back(mk(1'b1,1'b0,32'h40,1'b1,32'h40,4'd0,1'b1,1'b0, 1'b0,4'd0,32'd0,32'd0));
      vecs.push_back(mk(1'b1,1'b0,32'h40,1'b1,32'h40,4'd0,1'b1,1'b0, 1'b1,4'd0,32'd0,32'd0));
      vecs.push_back(mk(1'b1,1'b0,32'h40,1'b1,32'h40,4'd1,1'b1,1'b0, 1'b1,4'd0,32'd0,32'd0));
      vecs.push_back(mk(1'b1,1'b0,32'h40,1'b1,32'h40,4'd1,1'b1,1'b0, 1'b1,4'd0,32'd0,32'd0));
      vecs.push_back(mk(1'b1,1'b0,32'h40,1'b1,32'h40,4'd3,1'b1,1'b0, 1'b1,4'd0,32'd0,32'd0));
      vecs.push_back(mk(1'b1,1'b0,32'h40,1'b1,32'h40,4'd3,1'b1,1'b0, 1'b1,4'd0,32'd0,32'd0));
      // Three queries: GHR moves 0 -> 1 -> 3 -> 7
      vecs.push_back(mk(1'b1,1'b1,32'h40,1'b0,32'h0,4'd0,1'b0,1'b0, 1'b1,4'd0,32'd0,32'd0));
      vecs.push_back(mk(1'b1,1'b1,32'h40,1'b0,32'h0,4'd0,1'b0,1'b0, 1'b1,4'd1,32'd1,32'd0));
      vecs.push_back(mk(1'b1,1'b1,32'h40,1'b0,32'h0,4'd0,1'b0,1'b0, 1'b1,4'd3,32'd2,32'd0));
      vecs.push_back(mk(1'b1,1'b0,32'h40,1'b0,32'h0,4'd0,1'b0,1'b0, 1'b0,4'd7,32'd3,32'd0));
      // Repair beats a same-cycle taken query: GHR becomes 1010
      vecs.push_back(mk(1'b1,1'b1,32'h4E,1'b1,32'h204,4'd5,1'b0,1'b1, 1'b1,4'd7,32'd3,32'd0));
      // Repair back to GHR 0 without a query
      vecs.push_back(mk(1'b1,1'b0,32'h0A,1'b1,32'h300,4'd0,1'b0,1'b1, 1'b0,4'd10,32'd3,32'd1));
      // Read-before-write on counter[5]
      vecs.push_back(mk(1'b1,1'b1,32'h0A,1'b1,32'h0A,4'd0,1'b1,1'b0, 1'b0,4'd0,32'd3,32'd2));
      vecs.push_back(mk(1'b1,1'b0,32'h0A,1'b0,32'h0, 4'd0,1'b0,1'b0, 1'b1,4'd0,32'd4,32'd2));
      // rdy low: the query and update are both ignored
      vecs.push_back(mk(1'b0,1'b1,32'h0A,1'b0,32'h0, 4'd0,1'b0,1'b0, 1'b1,4'd0,32'd4,32'd2));
      vecs.push_back(mk(1'b0,1'b1,32'h0A,1'b1,32'h0C,4'd3,1'b0,1'b1, 1'b1,4'd0,32'd4,32'd2));
      vecs.push_back(mk(1'b1,1'b0,32'h0A,1'b0,32'h0, 4'd0,1'b0,1'b0, 1'b1,4'd0,32'd4,32'd2));

      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rdy = vecs[i].rdy; qen = vecs[i].qen; qpc = vecs[i].qpc; uen = vecs[i].uen;
         upc = vecs[i].upc; uh = vecs[i].uh; ut = vecs[i].ut; um = vecs[i].um;
         #1;
         chk($sformatf("vec%0d.query_taken", i), 32'(qt), 32'(vecs[i].e_taken));
         chk($sformatf("vec%0d.query_history", i), 32'(qh), 32'(vecs[i].e_hist));
         chk($sformatf("vec%0d.stat_predictions", i), sp, vecs[i].e_pred);
         chk($sformatf("vec%0d.stat_mispredicts", i), sm, vecs[i].e_misp);
      end

      // Asynchronous reset between edges: counter[5] = 2 and GHR = 0 here
      @(negedge clk);
      rdy = 1'b1; qen = 1'b1; qpc = 32'h0A; uen = 1'b0; um = 1'b0;
      #1 chk("pre_reset.query_taken", 32'(qt), 32'd1);
      @(negedge clk);
      qen = 1'b0;
      #1;
      chk("pre_reset.query_history", 32'(qh), 32'd1);
      chk("pre_reset.query_taken_idx4", 32'(qt), 32'd0);
      chk("pre_reset.stat_predictions", sp, 32'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset.query_history", 32'(qh), 32'd0);
      qpc = 32'h0A;
      #1;
      chk("async_reset.query_taken", 32'(qt), 32'd0);
      chk("async_reset.stat_predictions", sp, 32'd0);
      chk("async_reset.stat_mispredicts", sm, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Randomized traffic against the reference model
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rdy = ($urandom_range(0, 9) != 0);
         qen = 1'($urandom_range(0, 1));
         qpc = 32'($urandom_range(0, 255));
         uen = 1'($urandom_range(0, 1));
         upc = 32'($urandom_range(0, 255));
         uh  = HW'($urandom_range(0, (1 << HW) - 1));
         ut  = 1'($urandom_range(0, 1));
         um  = ($urandom_range(0, 3) == 0);
         #1;
         chk($sformatf("rand%0d.query_taken", c), 32'(qt), 32'(model_taken()));
         chk($sformatf("rand%0d.query_history", c), 32'(qh), 32'(mghr));
         chk($sformatf("rand%0d.stat_predictions", c), sp, 32'(mpred));
         chk($sformatf("rand%0d.stat_mispredicts", c), sm, 32'(mmisp));
         model_step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised branch direction predictor for the decoder front end. It replaces the fixed table of 2-bit counters indexed by PC with a gshare scheme: a table of CNT_WIDTH-bit saturating counters indexed by PC XOR a speculative global history register (GHR). The decoder queries it while decoding a branch. The reorder buffer trains it at branch resolution and repairs the GHR on a misprediction. It also keeps prediction and misprediction counters for performance runs.

## Interface
- INDEX_WIDTH, 6: table has 2^INDEX_WIDTH entries.
- CNT_WIDTH, 2: counter width, range 2..4.
- HIST_WIDTH, 4: GHR length, range 1..INDEX_WIDTH.

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global enable; when low, no state changes.
- query_en  input  1  decoder is predicting a conditional branch this cycle.
- query_pc  input  32  PC of that branch.
- query_taken  output  1  predicted direction (combinational).
- query_history  output  HIST_WIDTH  GHR value used for the query (combinational). The ROB stores it with the branch.
- update_en  input  1  a branch has resolved.
- update_pc  input  32  PC of the resolved branch.
- update_history  input  HIST_WIDTH  history captured at query time.
- update_taken  input  1  actual direction.
- update_mispredict  input  1  the prediction was wrong; repair the GHR.
- stat_predictions  output  32  number of accepted queries.
- stat_mispredicts  output  32  number of accepted mispredict updates.

## Operation
- Index function: idx(pc, h) = pc[INDEX_WIDTH:1] XOR zero-extend(h) to INDEX_WIDTH bits. Bit 0 is ignored because compressed instructions are supported.
- Query:
  - query_taken = MSB of counter[idx(query_pc, GHR)].
  - query_history = GHR.
  - Both are driven every cycle regardless of query_en.
- Speculative history: on an accepted query (query_en && rdy_in && !(update_en && update_mispredict)), GHR <= {GHR[HIST_WIDTH-2:0], query_taken}. When HIST_WIDTH = 1, GHR <= query_taken.
- Training: on update_en && rdy_in, the counter at idx(update_pc, update_history) moves toward update_taken.
  - +1 if taken, -1 if not taken.
  - Saturates at 2^CNT_WIDTH-1 and at 0.
- Repair: on update_en && update_mispredict && rdy_in:
  - GHR <= {update_history[HIST_WIDTH-2:0], update_taken}.
  - This overrides any query in the same cycle; that query's shift is discarded. The decoder is being flushed anyway.
- Statistics:
  - stat_predictions increments on each accepted query.
  - stat_mispredicts increments on each update with update_mispredict.
  - Both saturate at 32'hFFFFFFFF and never wrap.
- Reset (rst_n_in low, asynchronous and immediate):
  - Every counter becomes weakly not-taken, 2^(CNT_WIDTH-1)-1 (01 for 2-bit counters).
  - GHR = 0, both statistics = 0.
  - query_taken therefore reads 0 and query_history reads 0.
- Reset mid-operation: reset takes effect immediately; any pending query or update in that cycle is lost.
- rdy_in low: inputs are ignored and state is held. Outputs still reflect the current state.

## Timing
- Query path is combinational: table read plus XOR. No registered latency; the decoder samples the result in its decode cycle.
- GHR, counter and statistics updates are visible from the cycle after the accepting edge.
- Same-cycle query and update to the same index: the query sees the pre-update counter value (read-before-write).
- Update with update_mispredict = 0: trains the counter only; the GHR is untouched.
- Two events per cycle at most (one query, one update); no internal queueing, never stalls.

## Test plan
- Reset: hold rst_n_in low, release; query pc 0x0, 0x100, 0x7E with query_en low -> query_taken 0 and query_history 4'b0000 for all three; stat_predictions = stat_mispredicts = 0.
- Train and saturate: with GHR 0, send two updates pc 0x100, history 0, taken 1 -> counter[0] = 3 and query_taken = 1 for pc 0x100. Then send five not-taken updates -> counter stays at 0, query_taken = 0.
- Speculative history: train counter[idx(0x40, h)] high for h = 0, 1, 3. Then issue three consecutive queries at pc 0x40 -> GHR goes 0001, 0011, 0111 and stat_predictions = 3.
- Repair priority: in one cycle, assert query_en (predicting taken) together with update_en, update_mispredict, update_history 4'b0101, update_taken 0 -> next cycle query_history = 4'b1010; stat_mispredicts increments by 1; stat_predictions unchanged.
- Read-before-write: with counter[5] = 1, in one cycle query pc 0x0A and update pc 0x0A, history 0, taken 1 -> query_taken = 0 that cycle and 1 the next cycle.
- Stall and reset: with rdy_in low, apply a query and an update -> no state change. Then pull rst_n_in low between clock edges -> outputs clear immediately, without waiting for a clock edge.
